// File: rtl/exe_muldiv_seq_if.sv
// -----------------------------------------------------------------------------
// exe_muldiv_seq_if
//   Request/response bundle between the execute stage and the iterative
//   RV32M multiply/divide sequencer.
//
//   Handshake: the master raises start with funct3/op1/op2 stable and keeps
//   all of them stable until done. The sequencer takes the request on a
//   rising edge where it is ready (not busy) and kill is low. It answers with
//   a one-cycle done pulse, and result holds its value from that pulse until
//   a later operation completes or reset. kill aborts any in-flight operation
//   and overrides a start in the same cycle.
//
//   Signals:
//     start  : request
//     kill   : abort current/requested operation
//     funct3 : M-extension operation select
//     op1    : rs1 value (multiplicand / dividend)
//     op2    : rs2 value (multiplier / divisor)
//     busy   : stall request, high while iterating
//     done   : one-cycle completion pulse
//     result : final value
// -----------------------------------------------------------------------------
interface exe_muldiv_seq_if;
    logic        start;
    logic        kill;
    logic [2:0]  funct3;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        busy;
    logic        done;
    logic [31:0] result;

    modport master (
        output start, kill, funct3, op1, op2,
        input  busy, done, result
    );

    modport slave (
        input  start, kill, funct3, op1, op2,
        output busy, done, result
    );
endinterface

// File: rtl/exe_muldiv_seq.sv
// -----------------------------------------------------------------------------
// exe_muldiv_seq
//   Iterative RV32M multiply/divide sequencer. One 32-step shift-add multiply
//   or restoring divide runs over a single shared 34-bit adder and a 64-bit
//   product/remainder shift register. Division by zero and signed overflow
//   finish immediately without iterating.
//
//   Build option: define EXE_MULDIV_FAST_MUL_EN to finish multiplies in one
//   cycle on a 64-bit hardware multiplier; divides stay iterative.
//
//   Ports:
//     clk     : clock, all state on the rising edge
//     rst     : synchronous reset, active-low
//     md      : request/response bundle (slave side)
//     state_o : current sequencer state (0 IDLE, 1 CALC, 2 DONE) for observation
// -----------------------------------------------------------------------------
module exe_muldiv_seq (
    input  logic                    clk,
    input  logic                    rst,
    exe_muldiv_seq_if.slave         md,
    output logic [1:0]              state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] prod_q, prod_d;    // {partial sum/remainder, multiplier/quotient}
    logic [31:0] opb_q, opb_d;      // multiplicand or divisor magnitude
    logic [2:0]  f3_q, f3_d;
    logic        neg_q, neg_d;      // final value must be negated
    logic [31:0] result_q, result_d;

    // ---------------- request decode ----------------
    logic        a_signed, b_signed, a_neg, b_neg, is_div, is_rem;
    logic [31:0] a_mag, b_mag;
    logic        div_zero, div_ovf, special;
    logic [31:0] special_res;
    logic        neg_in;

    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (md.funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            3'b010:  a_signed = 1'b1;
            default: ;
        endcase
    end

    assign is_div   = md.funct3[2];
    assign is_rem   = md.funct3[1];
    assign a_neg    = a_signed & md.op1[31];
    assign b_neg    = b_signed & md.op2[31];
    assign a_mag    = a_neg ? (~md.op1 + 32'd1) : md.op1;
    assign b_mag    = b_neg ? (~md.op2 + 32'd1) : md.op2;
    assign div_zero = is_div & (md.op2 == 32'd0);
    assign div_ovf  = is_div & a_signed & (md.op1 == 32'h8000_0000) & (md.op2 == 32'hFFFF_FFFF);
    assign special  = div_zero | div_ovf;

    always_comb begin
        special_res = 32'd0;
        if (div_zero)
            special_res = is_rem ? md.op1 : 32'hFFFF_FFFF;
        else if (div_ovf)
            special_res = is_rem ? 32'd0 : 32'h8000_0000;
    end

    // Remainder takes the dividend's sign; everything else the XOR of signs.
    assign neg_in = (is_div & is_rem) ? a_neg : (a_neg ^ b_neg);

`ifdef EXE_MULDIV_FAST_MUL_EN
    logic signed [63:0] fast_a, fast_b, fast_p;
    logic [31:0]        fast_res;
    assign fast_a   = {{32{a_neg}}, md.op1};
    assign fast_b   = {{32{b_neg}}, md.op2};
    assign fast_p   = fast_a * fast_b;
    assign fast_res = (md.funct3[1:0] == 2'b00) ? fast_p[31:0] : fast_p[63:32];
`endif

    // ---------------- shared iteration datapath ----------------
    // Multiply: hi += (lo[0] ? mcand : 0), then shift the 65-bit pair right.
    // Divide: shift {hi,lo} left one, trial-subtract the divisor from the
    // 33-bit partial remainder; carry-in turns the adder into a subtractor.
    logic        calc_div;
    logic [32:0] shifted;
    logic [33:0] add_a, add_b, sum;
    logic [63:0] step;

    assign calc_div = f3_q[2];
    assign shifted  = {prod_q[63:32], prod_q[31]};
    assign add_a    = calc_div ? {1'b0, shifted} : {2'b00, prod_q[63:32]};
    assign add_b    = calc_div ? ~{2'b00, opb_q}
                               : {2'b00, (prod_q[0] ? opb_q : 32'd0)};
    assign sum      = add_a + add_b + {33'd0, calc_div};

    always_comb begin
        if (!calc_div)
            step = {sum[32:0], prod_q[31:1]};
        else if (!sum[33])   // no borrow: divisor fits, keep the difference
            step = {sum[31:0], prod_q[30:0], 1'b1};
        else
            step = {shifted[31:0], prod_q[30:0], 1'b0};
    end

    // Sign correction of the last step's value.
    logic [63:0] mul_full;
    logic [31:0] div_raw, fin_res;
    assign mul_full = neg_q ? (~step + 64'd1) : step;
    assign div_raw  = f3_q[1] ? step[63:32] : step[31:0];

    always_comb begin
        if (calc_div)
            fin_res = neg_q ? (~div_raw + 32'd1) : div_raw;
        else if (f3_q[1:0] == 2'b00)
            fin_res = mul_full[31:0];
        else
            fin_res = mul_full[63:32];
    end

    // ---------------- sequencer ----------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        opb_d    = opb_q;
        f3_d     = f3_q;
        neg_d    = neg_q;
        result_d = result_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (md.start && !md.kill) begin
                    f3_d   = md.funct3;
                    neg_d  = neg_in;
                    prod_d = {32'd0, (is_div ? a_mag : b_mag)};
                    opb_d  = is_div ? b_mag : a_mag;
                    cnt_d  = 5'd31;
                    state_d = S_CALC;
                    if (special) begin
                        result_d = special_res;
                        state_d  = S_DONE;
                    end
`ifdef EXE_MULDIV_FAST_MUL_EN
                    if (!is_div) begin
                        result_d = fast_res;
                        state_d  = S_DONE;
                    end
`endif
                end
            end
            S_CALC: begin
                prod_d = step;
                cnt_d  = cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    result_d = fin_res;
                    state_d  = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over everything, including the final step's write-back.
        if (md.kill) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 5'd0;
            prod_q   <= 64'd0;
            opb_q    <= 32'd0;
            f3_q     <= 3'd0;
            neg_q    <= 1'b0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            opb_q    <= opb_d;
            f3_q     <= f3_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign md.busy   = (state_q == S_CALC);
    assign md.done   = (state_q == S_DONE);
    assign md.result = result_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_exe_muldiv_seq.sv
// -----------------------------------------------------------------------------
// tb_exe_muldiv_seq
//   Self-checking bench for exe_muldiv_seq. Cycle numbering: the edge that
//   samples start is T; the first sample taken 1 time unit after that edge is
//   cycle T+1.
// -----------------------------------------------------------------------------
module tb_exe_muldiv_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dut_state;

    always #5 clk = ~clk;

    exe_muldiv_seq_if bus();

    exe_muldiv_seq dut (
        .clk     (clk),
        .rst     (rst),
        .md      (bus),
        .state_o (dut_state)
    );

`ifdef EXE_MULDIV_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];

    // ---------------- reference model ----------------
    function automatic logic is_signed_a(input logic [2:0] f3);
        return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd6);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] f3);
        return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd4) || (f3 == 3'd6);
    endfunction

    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p, q, r;
        logic [63:0] pv;
        sa = is_signed_a(f3) ? longint'($signed(a)) : longint'({32'd0, a});
        sb = is_signed_b(f3) ? longint'($signed(b)) : longint'({32'd0, b});
        if (!f3[2]) begin
            p  = sa * sb;
            pv = p;
            return (f3 == 3'd0) ? pv[31:0] : pv[63:32];
        end
        if (b == 32'd0)
            return f3[1] ? a : 32'hFFFF_FFFF;
        if (is_signed_a(f3) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return f3[1] ? 32'd0 : 32'h8000_0000;
        q = sa / sb;
        r = sa % sb;
        pv = f3[1] ? r : q;
        return pv[31:0];
    endfunction

    function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (!f3[2]) return FAST ? 1 : 33;
        if (b == 32'd0) return 1;
        if (is_signed_a(f3) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // ---------------- driver ----------------
    // Called 1 unit after a rising edge with start low. Returns the result,
    // the cycle of done (0 on timeout) and how many cycles busy was high.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int busy_cnt);
        bus.funct3 = f3;
        bus.op1    = a;
        bus.op2    = b;
        bus.start  = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 0;
        busy_cnt = 0;
        for (int k = 1; k <= 60; k++) begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                lat = k;
                break;
            end
            @(posedge clk); #1;
        end
        res = bus.result;
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        bus.start = 1'b0;
        bus.kill = 1'b0;
        bus.funct3 = 3'd0;
        bus.op1 = 32'd0;
        bus.op2 = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b done=%b result=%h, required 0 0 00000000",
                     bus.busy, bus.done, bus.result);
        end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    typedef struct packed {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
    } vec_t;

    task automatic test_directed();
        vec_t        vecs[14];
        logic [31:0] res;
        int          lat, bc, el;
        vecs = '{
            '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB},
            '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE},
            '{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF},
            '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000},
            '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD},
            '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF},
            '{3'd5, 32'd100,        32'd7,         32'd14},
            '{3'd7, 32'd100,        32'd7,         32'd2},
            '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF},
            '{3'd6, 32'd5,          32'd0,         32'd5},
            '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000},
            '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0},
            '{3'd5, 32'd123,        32'd0,         32'hFFFF_FFFF},
            '{3'd7, 32'd77,         32'd0,         32'd77}
        };
        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].f3, vecs[i].a, vecs[i].b, res, lat, bc);
            el = exp_lat(vecs[i].f3, vecs[i].a, vecs[i].b);
            n_tests++;
            if (res !== vecs[i].e) begin
                n_fail++;
                $display("FAIL directed_result[%0d]: got %h, required %h", i, res, vecs[i].e);
            end
            n_tests++;
            if (lat != el) begin
                n_fail++;
                $display("FAIL directed_latency[%0d]: done at T+%0d, required T+%0d", i, lat, el);
            end
            n_tests++;
            if (bc != el - 1) begin
                n_fail++;
                $display("FAIL directed_busy[%0d]: busy %0d cycles, required %0d", i, bc, el - 1);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic [31:0] a, b, res, e;
        int          lat, bc, el;
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: a = 32'($urandom_range(0, 300));
                default: ;
            endcase
            exp_q.push_back(ref_model(f3, a, b));
            el = exp_lat(f3, a, b);
            run_op(f3, a, b, res, lat, bc);
            e = exp_q.pop_front();
            n_tests++;
            if (res !== e) begin
                n_fail++;
                $display("FAIL random_result[%0d] f3=%0d a=%h b=%h: got %h, required %h", i, f3, a, b, res, e);
            end
            n_tests++;
            if (lat != el || bc != el - 1) begin
                n_fail++;
                $display("FAIL random_timing[%0d] f3=%0d: done T+%0d busy %0d, required T+%0d busy %0d",
                         i, f3, lat, bc, el, el - 1);
            end
        end
    endtask

    task automatic test_kill();
        logic [31:0] res;
        int          lat, bc, seen;
        run_op(3'd7, 32'd100, 32'd7, res, lat, bc);   // result now 2
        n_tests++;
        if (res !== 32'd2) begin
            n_fail++;
            $display("FAIL kill_setup: got %h, required 00000002", res);
        end
        bus.funct3 = 3'd5; bus.op1 = 32'd1000; bus.op2 = 32'd3; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;                              // cycle T+1
        repeat (9) begin @(posedge clk); #1; end       // cycle T+10
        bus.kill = 1'b1;
        @(posedge clk); #1;                            // cycle T+11
        bus.kill = 1'b0;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'd2) begin
            n_fail++;
            $display("FAIL kill_abort: busy=%b done=%b result=%h, required 0 0 00000002",
                     bus.busy, bus.done, bus.result);
        end
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.done || bus.busy) seen++;
            @(posedge clk); #1;
        end
        n_tests++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL kill_quiet: busy/done seen %0d cycles after kill, required 0", seen);
        end
        run_op(3'd5, 32'd9, 32'd3, res, lat, bc);
        n_tests++;
        if (res !== 32'd3 || lat != 33) begin
            n_fail++;
            $display("FAIL kill_reissue: got %h at T+%0d, required 00000003 at T+33", res, lat);
        end
    endtask

    task automatic test_kill_last_step();
        // Result is 3 from the previous test.
        bus.funct3 = 3'd4; bus.op1 = 32'hFFFF_FF9C; bus.op2 = 32'd7; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;                              // cycle T+1
        repeat (31) begin @(posedge clk); #1; end      // cycle T+32, last step
        n_tests++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL kill_last_busy: busy=%b at T+32, required 1", bus.busy);
        end
        bus.kill = 1'b1;
        @(posedge clk); #1;
        bus.kill = 1'b0;
        n_tests++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.result !== 32'd3) begin
            n_fail++;
            $display("FAIL kill_last_step: done=%b busy=%b result=%h, required 0 0 00000003",
                     bus.done, bus.busy, bus.result);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_start_with_kill();
        bus.funct3 = 3'd4; bus.op1 = 32'd5; bus.op2 = 32'd0;   // would finish at T+1
        bus.start = 1'b1; bus.kill = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.kill = 1'b0;
        n_tests++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.result !== 32'd3) begin
            n_fail++;
            $display("FAIL start_kill: done=%b busy=%b result=%h, required 0 0 00000003",
                     bus.done, bus.busy, bus.result);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        bus.funct3 = 3'd5; bus.op1 = 32'd1000; bus.op2 = 32'd3; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;                              // cycle T+1
        repeat (4) begin @(posedge clk); #1; end       // cycle T+5
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid: busy=%b done=%b result=%h, required 0 0 00000000",
                     bus.busy, bus.done, bus.result);
        end
        repeat (40) @(posedge clk);
        #1;
        n_tests++;
        if (bus.done !== 1'b0 || bus.result !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_quiet: done=%b result=%h, required 0 00000000", bus.done, bus.result);
        end
    endtask

    task automatic test_back_to_back();
        int d1, d2;
        bus.funct3 = 3'd5; bus.op1 = 32'd100; bus.op2 = 32'd7; bus.start = 1'b1;
        @(posedge clk); #1;
        d1 = 0;
        for (int k = 1; k <= 60; k++) begin
            if (bus.done) begin d1 = k; break; end
            @(posedge clk); #1;
        end
        n_tests++;
        if (d1 != 33 || bus.result !== 32'd14) begin
            n_fail++;
            $display("FAIL b2b_first: got %h at T+%0d, required 0000000e at T+33", bus.result, d1);
        end
        // Still in the done cycle: present the next operation with start held.
        bus.funct3 = 3'd6; bus.op1 = 32'hFFFF_FFF9; bus.op2 = 32'd2;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n_tests++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_accept: busy=%b done=%b after done cycle, required 1 0", bus.busy, bus.done);
        end
        d2 = 0;
        for (int k = 1; k <= 60; k++) begin
            if (bus.done) begin d2 = k; break; end
            @(posedge clk); #1;
        end
        n_tests++;
        if (d2 != 33 || bus.result !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL b2b_second: got %h %0d cycles after first done, required ffffffff after 33",
                     bus.result, d2);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_kill();
        test_kill_last_step();
        test_start_with_kill();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
